// File: rtl/fir_seq_mac.sv
// fir_seq_mac: time-multiplexed FIR filter built around one shared signed MAC.
// A sample accepted in IDLE is shifted into the delay line. MAC then spends
// NUM_TAPS cycles accumulating x[k]*c[k]. OUT loads the rounded, saturated
// result and holds it until the downstream side takes it.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   coeff_we/addr/data     coefficient write port (ignored while in MAC)
//   in_valid/ready/data    input sample handshake
//   out_valid/ready/data   output result handshake
//   busy                   high while accumulating
//   overflow               sticky saturation flag, cleared only by reset
module fir_seq_mac #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COEFF_W   = 8,
    parameter int unsigned NUM_TAPS  = 4,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          coeff_we,
    input  logic [$clog2(NUM_TAPS)-1:0]   coeff_addr,
    input  logic signed [COEFF_W-1:0]     coeff_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic                          busy,
    output logic                          overflow
);

    localparam int unsigned ADDR_W = $clog2(NUM_TAPS);
    localparam int unsigned PROD_W = DATA_W + COEFF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_TAPS);
    // One spare bit so adding the rounding constant can never wrap.
    localparam int unsigned RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] SAT_MAX =
        {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t state, next_state;

    logic signed [DATA_W-1:0]  x [NUM_TAPS];
    logic signed [COEFF_W-1:0] c [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [ADDR_W-1:0]         k;

    logic                      accept_c;
    logic                      last_tap_c;
    logic                      coeff_wr_c;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [ACC_W-1:0]   acc_next_c;
    logic signed [RND_W-1:0]   acc_ext_c;
    logic signed [RND_W-1:0]   scaled_c;
    logic signed [DATA_W-1:0]  sat_data_c;
    logic                      sat_hit_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        last_tap_c = 1'b0;
        coeff_wr_c = 1'b0;
        case (state)
            ST_IDLE: begin
                coeff_wr_c = coeff_we;
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    next_state = ST_MAC;
                end
            end
            ST_MAC: begin
                last_tap_c = (k == ADDR_W'(NUM_TAPS - 1));
                if (last_tap_c) begin
                    next_state = ST_OUT;
                end
            end
            ST_OUT: begin
                coeff_wr_c = coeff_we;
                if (out_valid && out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Shared multiply-accumulate
    always_comb begin
        prod_c     = PROD_W'(x[k]) * PROD_W'(c[k]);
        acc_next_c = acc + ACC_W'(prod_c);
        acc_ext_c  = RND_W'(acc);
    end

    // Round half up, then arithmetic shift
    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (OUT_SHIFT - 1);
            assign scaled_c = (acc_ext_c + RND_HALF) >>> OUT_SHIFT;
        end else begin : g_no_round
            assign scaled_c = acc_ext_c;
        end
    endgenerate

    // Clamp to the output range
    always_comb begin
        sat_hit_c  = 1'b0;
        sat_data_c = scaled_c[DATA_W-1:0];
        if (scaled_c > SAT_MAX) begin
            sat_hit_c  = 1'b1;
            sat_data_c = SAT_MAX[DATA_W-1:0];
        end else if (scaled_c < SAT_MIN) begin
            sat_hit_c  = 1'b1;
            sat_data_c = SAT_MIN[DATA_W-1:0];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            acc       <= '0;
            k         <= '0;
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
        end else begin
            in_ready <= (next_state == ST_IDLE);
            busy     <= (next_state == ST_MAC);

            if (coeff_wr_c) begin
                c[coeff_addr] <= coeff_data;
            end

            if (accept_c) begin
                x[0] <= in_data;
                for (int i = 1; i < int'(NUM_TAPS); i++) begin
                    x[i] <= x[i-1];
                end
                acc <= '0;
                k   <= '0;
            end

            if (state == ST_MAC) begin
                acc <= acc_next_c;
                k   <= last_tap_c ? '0 : k + ADDR_W'(1);
            end

            // First OUT cycle loads the result from the completed accumulator.
            if (state == ST_OUT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= sat_data_c;
                    if (sat_hit_c) begin
                        overflow <= 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// tb_fir_seq_mac: directed bench for fir_seq_mac. A default instance
// (4 taps, no shift) covers impulse, saturation, backpressure, coefficient
// write timing and mid-operation reset; a 2-tap OUT_SHIFT=2 instance covers
// rounding.
module tb_fir_seq_mac;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic              coeff_we = 1'b0;
    logic [1:0]        coeff_addr = '0;
    logic signed [7:0] coeff_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [7:0] out_data;
    logic              busy;
    logic              overflow;

    // Rounding instance
    logic              r_coeff_we = 1'b0;
    logic [0:0]        r_coeff_addr = '0;
    logic signed [7:0] r_coeff_data = '0;
    logic              r_in_valid = 1'b0;
    logic              r_in_ready;
    logic signed [7:0] r_in_data = '0;
    logic              r_out_valid;
    logic              r_out_ready = 1'b1;
    logic signed [7:0] r_out_data;
    logic              r_busy;
    logic              r_overflow;

    fir_seq_mac dut (
        .clk(clk), .reset(reset),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .overflow(overflow)
    );

    fir_seq_mac #(.NUM_TAPS(2), .OUT_SHIFT(2)) dut_r (
        .clk(clk), .reset(reset),
        .coeff_we(r_coeff_we), .coeff_addr(r_coeff_addr), .coeff_data(r_coeff_data),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .busy(r_busy), .overflow(r_overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic signed [7:0] din;
        logic signed [7:0] dout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_coeff(input logic [1:0] a, input logic signed [7:0] d);
        coeff_we = 1'b1; coeff_addr = a; coeff_data = d;
        tick();
        coeff_we = 1'b0;
    endtask

    // Offer a sample (optionally with a coefficient write on the accept edge),
    // then wait for out_valid. lat = edges from accept to out_valid.
    task automatic send_sample(input logic signed [7:0] d, input logic we,
                               input logic [1:0] a, input logic signed [7:0] cd,
                               output logic signed [7:0] res, output int lat);
        int guard = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && guard < 30) begin tick(); guard++; end
        if (!in_ready) check("accept_timeout", 0, 1);
        coeff_we = we; coeff_addr = a; coeff_data = cd;
        tick();
        in_valid = 1'b0; coeff_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin tick(); lat++; end
        res = out_data;
    endtask

    task automatic r_send(input logic signed [7:0] d, output logic signed [7:0] res,
                          output int lat);
        int guard = 0;
        r_in_valid = 1'b1; r_in_data = d;
        while (!r_in_ready && guard < 30) begin tick(); guard++; end
        if (!r_in_ready) check("r_accept_timeout", 0, 1);
        tick();
        r_in_valid = 1'b0;
        lat = 0;
        while (!r_out_valid && lat < 30) begin tick(); lat++; end
        res = r_out_data;
    endtask

    task automatic load_ramp_coeffs();
        for (int i = 0; i < 4; i++) write_coeff(2'(i), 8'(i + 1));
    endtask

    initial begin
        logic signed [7:0] res;
        int lat;
        int guard;

        // Impulse then arbitrary samples against coeffs 1,2,3,4.
        vecs[0] = '{ 8'sd1,  8'sd1};
        vecs[1] = '{ 8'sd0,  8'sd2};
        vecs[2] = '{ 8'sd0,  8'sd3};
        vecs[3] = '{ 8'sd0,  8'sd4};
        vecs[4] = '{ 8'sd2,  8'sd2};
        vecs[5] = '{-8'sd1,  8'sd3};
        vecs[6] = '{ 8'sd5,  8'sd9};
        vecs[7] = '{ 8'sd10, 8'sd25};

        tick();
        pulse_reset();
        check("rst_in_ready",  int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_overflow",  int'(overflow), 0);
        check("rst_out_data",  int'(out_data), 0);
        check("r_rst_in_ready", int'(r_in_ready), 1);

        // Table-driven impulse / general vectors
        load_ramp_coeffs();
        for (int i = 0; i < 8; i++) begin
            send_sample(vecs[i].din, 1'b0, 2'd0, 8'sd0, res, lat);
            check($sformatf("vec%0d_data", i), int'(res), int'(vecs[i].dout));
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_overflow", i), int'(overflow), 0);
        end

        // Coefficient write during MAC is dropped
        pulse_reset();
        load_ramp_coeffs();
        in_valid = 1'b1; in_data = 8'sd1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 8'sd5;
        tick();
        coeff_we = 1'b0;
        guard = 0;
        while (!out_valid && guard < 30) begin tick(); guard++; end
        check("busy_write_dropped", int'(out_data), 1);
        for (int i = 0; i < 4; i++) send_sample(8'sd0, 1'b0, 2'd0, 8'sd0, res, lat);
        check("flush_zero", int'(res), 0);

        // Write in IDLE is used by the next sample
        tick(); tick();
        write_coeff(2'd0, 8'sd5);
        send_sample(8'sd1, 1'b0, 2'd0, 8'sd0, res, lat);
        check("idle_write_used", int'(res), 5);
        for (int i = 0; i < 4; i++) send_sample(8'sd0, 1'b0, 2'd0, 8'sd0, res, lat);

        // Write on the accept edge is used by that same sample
        send_sample(8'sd1, 1'b1, 2'd0, 8'sd6, res, lat);
        check("accept_edge_write", int'(res), 6);

        // Backpressure: result held, pending sample not taken
        pulse_reset();
        load_ramp_coeffs();
        out_ready = 1'b0;
        send_sample(8'sd7, 1'b0, 2'd0, 8'sd0, res, lat);
        check("bp_first_data", int'(res), 7);
        in_valid = 1'b1; in_data = 8'sd9;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), int'(out_valid), 1);
            check($sformatf("bp_hold_data%0d", i), int'(out_data), 7);
            check($sformatf("bp_hold_in_ready%0d", i), int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_pending_busy", int'(busy), 1);
        guard = 0;
        while (!out_valid && guard < 30) begin tick(); guard++; end
        check("bp_pending_result", int'(out_data), 23);

        // Positive saturation
        pulse_reset();
        for (int i = 0; i < 4; i++) write_coeff(2'(i), 8'sd127);
        for (int i = 0; i < 4; i++) begin
            send_sample(8'sd127, 1'b0, 2'd0, 8'sd0, res, lat);
            check($sformatf("sat_pos%0d", i), int'(res), 127);
        end
        check("sat_pos_overflow", int'(overflow), 1);

        // Negative saturation after a fresh reset
        pulse_reset();
        check("sat_rst_overflow", int'(overflow), 0);
        for (int i = 0; i < 4; i++) write_coeff(2'(i), 8'sd127);
        send_sample(-8'sd128, 1'b0, 2'd0, 8'sd0, res, lat);
        check("sat_neg_data", int'(res), -128);
        check("sat_neg_overflow", int'(overflow), 1);

        // Reset at k=2 in MAC
        tick();
        in_valid = 1'b1; in_data = 8'sd100;
        guard = 0;
        while (!in_ready && guard < 30) begin tick(); guard++; end
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("midrst_busy_before", int'(busy), 1);
        pulse_reset();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_overflow", int'(overflow), 0);
        send_sample(8'sd50, 1'b0, 2'd0, 8'sd0, res, lat);
        check("midrst_zero_coeff", int'(res), 0);
        check("midrst_latency", lat, 5);
        check("midrst_overflow_after", int'(overflow), 0);

        // Rounding instance: c0=3, c1=0
        r_coeff_we = 1'b1; r_coeff_addr = 1'b0; r_coeff_data = 8'sd3;
        tick();
        r_coeff_we = 1'b0;
        r_send(8'sd2, res, lat);
        check("rnd_pos", int'(res), 2);
        check("rnd_latency", lat, 3);
        r_send(-8'sd2, res, lat);
        check("rnd_neg", int'(res), -1);
        r_send(8'sd1, res, lat);
        check("rnd_small", int'(res), 1);
        check("rnd_overflow", int'(r_overflow), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
